// File: rtl/store_buffer_if.sv
// Bus bundle between the MEM-stage load/store port, the store buffer and Data_Memory.
// The slave modport is the store buffer. The master modport is its environment: the CPU
// request side plus the memory read-data return.
interface store_buffer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_re;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          buf_empty;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata, buf_empty,
        input  mem_address, mem_wdata, mem_write, mem_read
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata, buf_empty,
        output mem_address, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/store_buffer.sv
// Write buffer between the MEM-stage load/store port and Data_Memory.
// Stores retire into a DEPTH-entry FIFO in one cycle and drain whenever the memory port is
// not used by a load. Loads take one cycle: either forwarded from the youngest matching
// buffered store or read from memory.
// Optional feature macro: STORE_FWD_EN (store-to-load forwarding). When undefined, a load
// waits until the buffer has fully drained and then reads memory.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input logic             CLK,
    input logic             RST_N,
    store_buffer_if.slave   bus_io
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {
        StRun,
        StLoadWait
    } state_e;

    // Control state
    state_e          state_q;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rd_mem_q;
    logic [DW-1:0]   rdata_q;

    // Entry storage
    logic [AW-1:0]   ent_addr_q [DEPTH];
    logic [DW-1:0]   ent_data_q [DEPTH];

    // Decoded request / port arbitration
    logic            running;
    logic            full;
    logic            empty;
    logic            store_acc;
    logic            load_req;
    logic            load_acc;
    logic            load_mem;
    logic            drain;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;

    assign running = (state_q == StRun);
    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);

    // A slot freed by this cycle's drain is deliberately not reused in the same cycle.
    assign store_acc = running && bus_io.cpu_we && !full;

    // Store wins when both requests are raised together; the load is not taken.
    assign load_req  = running && bus_io.cpu_re && !bus_io.cpu_we;

`ifdef STORE_FWD_EN
    logic [PtrW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry is the one left in fwd_data.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (ent_addr_q[fwd_idx] == bus_io.cpu_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[fwd_idx];
            end
        end
    end

    // A full buffer blocks loads so draining cannot be starved by a stream of loads.
    assign load_acc = load_req && !full;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;

    // Without forwarding memory is only coherent once every buffered store has landed.
    assign load_acc = load_req && empty;
`endif

    assign load_mem = load_acc && !fwd_hit;

    // The memory port goes to a load first; otherwise the head entry drains.
    assign drain    = !empty && !load_mem;

    // Request handshake back to the pipeline
    always_comb begin
        bus_io.cpu_stall = 1'b0;
        if (!running) begin
            bus_io.cpu_stall = bus_io.cpu_we || bus_io.cpu_re;
        end else if (bus_io.cpu_we) begin
            bus_io.cpu_stall = !store_acc;
        end else if (bus_io.cpu_re) begin
            bus_io.cpu_stall = !load_acc;
        end
    end

    // Data_Memory control: address and data are zero whenever the port is idle
    always_comb begin
        bus_io.mem_read    = load_mem;
        bus_io.mem_write   = drain;
        bus_io.mem_address = '0;
        bus_io.mem_wdata   = '0;
        if (load_mem) begin
            bus_io.mem_address = bus_io.cpu_addr;
        end else if (drain) begin
            bus_io.mem_address = ent_addr_q[head_q];
            bus_io.mem_wdata   = ent_data_q[head_q];
        end
    end

    // Load response: memory data passes straight through in the cycle after mem_read
    always_comb begin
        bus_io.cpu_rvalid = (state_q == StLoadWait);
        bus_io.cpu_rdata  = rdata_q;
        if ((state_q == StLoadWait) && rd_mem_q) begin
            bus_io.cpu_rdata = bus_io.mem_rdata;
        end
    end

    assign bus_io.buf_empty = empty;

    // FIFO pointer and occupancy next-state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CntW'(store_acc) - CntW'(drain);
        if (store_acc) begin
            tail_d = tail_q + PtrW'(1);
        end
        if (drain) begin
            head_d = head_q + PtrW'(1);
        end
    end

    // FIFO pointers and occupancy; reset discards every buffered store
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload; validity is tracked by head/count so no reset is needed here
    always_ff @(posedge CLK) begin
        if (store_acc) begin
            ent_addr_q[tail_q] <= bus_io.cpu_addr;
            ent_data_q[tail_q] <= bus_io.cpu_wdata;
        end
    end

    // Load FSM: one wait cycle per accepted load, with registered response source and data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StRun;
            rd_mem_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (load_acc) begin
                        state_q  <= StLoadWait;
                        rd_mem_q <= load_mem;
                        if (!load_mem) begin
                            rdata_q <= fwd_data;
                        end
                    end
                end
                StLoadWait: begin
                    state_q  <= StRun;
                    rd_mem_q <= 1'b0;
                    // Keep the last returned word visible after the response cycle.
                    if (rd_mem_q) begin
                        rdata_q <= bus_io.mem_rdata;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Sanity checks on the memory port and occupancy
    a_rw_excl: assert property (@(posedge CLK) disable iff (!RST_N)
        !(bus_io.mem_read && bus_io.mem_write));
    a_count_max: assert property (@(posedge CLK) disable iff (!RST_N)
        count_q <= CntW'(DEPTH));
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random stores/loads.
// The reference model is architectural: a golden word map updated when a store is accepted,
// plus an in-order queue of stores that must appear on the memory write port.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    store_buffer_if #(.AW(32), .DW(32)) bus ();

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (32),
        .DW    (32)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .bus_io (bus)
    );

    // Byte-addressed Data_Memory model, mem[i] = i initially, synchronous read
    logic [7:0] mem_b [256];
    initial begin
        for (int i = 0; i < 256; i++) mem_b[i] = 8'(i);
    end

    always @(posedge CLK) begin
        if (bus.mem_write) begin
            for (int k = 0; k < 4; k++) begin
                mem_b[bus.mem_address[7:0] + 8'(k)] = bus.mem_wdata[8*k +: 8];
            end
        end
        if (bus.mem_read) begin
            bus.mem_rdata <= mem_word(bus.mem_address);
        end
    end

    // Reference state
    ent_t        q[$];
    logic [31:0] gold [logic [31:0]];
    int          tests = 0;
    int          fails = 0;
    int          writes = 0;
    bit          drain_now = 1'b0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem_b[b + 8'd3], mem_b[b + 8'd2], mem_b[b + 8'd1], mem_b[b]};
    endfunction

    function automatic logic [31:0] golden(logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return mem_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory-port monitor: ordering of drains, arbitration and idle values
    always @(negedge CLK) begin
        if (RST_N) begin
            check("rw_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
            check("buf_empty", 32'(bus.buf_empty), 32'(q.size() == 0));
            check("drain_en", 32'(bus.mem_write), 32'((q.size() != 0) && !bus.mem_read));
            if (bus.mem_write && q.size() != 0) begin
                check("drain_addr", bus.mem_address, q[0].a);
                check("drain_data", bus.mem_wdata, q[0].d);
                drain_now = 1'b1;
                writes++;
            end
            if (!bus.mem_write && !bus.mem_read) begin
                check("idle_addr", bus.mem_address, 32'd0);
                check("idle_wdata", bus.mem_wdata, 32'd0);
            end
        end
    end

    // Retire the drained entry from the model just after the edge that wrote it
    always @(posedge CLK) begin
        #2;
        if (drain_now) begin
            drain_now = 1'b0;
            if (q.size() != 0) q.delete(0);
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bit done;
        bit st;
        done = 1'b0;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge CLK);
            #1;
            st = bus.cpu_stall;
            check("store_stall", 32'(st), 32'(q.size() >= DEPTH));
            @(posedge CLK);
            if (!st) begin
                q.push_back('{a: a, d: d});
                gold[a] = d;
                done = 1'b1;
            end
            #1;
        end
        bus.cpu_we = 1'b0;
        if (!done) check("store_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] got);
        bit          done;
        bit          st;
        bit          hit;
        logic [31:0] exp;
        done = 1'b0;
        exp  = '0;
        got  = '0;
        bus.cpu_addr = a;
        bus.cpu_re   = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge CLK);
            #1;
            st = bus.cpu_stall;
            check("load_stall", 32'(st),
                  32'(Fwd ? (q.size() >= DEPTH) : (q.size() != 0)));
            if (!st) begin
                hit = 1'b0;
                foreach (q[i]) if (q[i].a == a) hit = 1'b1;
                check("load_mem_read", 32'(bus.mem_read), 32'(!(Fwd && hit)));
                if (bus.mem_read) check("load_addr", bus.mem_address, a);
                exp = golden(a);
            end
            @(posedge CLK);
            #1;
            if (!st) done = 1'b1;
        end
        bus.cpu_re = 1'b0;
        if (done) begin
            @(negedge CLK);
            check("load_rvalid", 32'(bus.cpu_rvalid), 32'd1);
            check("load_rdata", bus.cpu_rdata, exp);
            got = bus.cpu_rdata;
            @(posedge CLK);
            #1;
        end else begin
            check("load_timeout", 32'(done), 32'd1);
        end
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 50 && !bus.buf_empty; n++) begin
            @(posedge CLK);
            #1;
        end
        check("drain_timeout", 32'(bus.buf_empty), 32'd1);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 32'(bus.buf_empty), 32'd1);
        check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        check({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
        check({tag, "_rdata"}, bus.cpu_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int          w0;

        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;

        // Power-on reset
        #1;
        check_reset_outputs("por");
        check("por_stall", 32'(bus.cpu_stall), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Two stores drain in order, little-endian bytes
        w0 = writes;
        do_store(32'h10, 32'hA1B2C3D4);
        do_store(32'h14, 32'h11111111);
        wait_empty();
        check("two_writes", 32'(writes - w0), 32'd2);
        check("byte10", 32'(mem_b[8'h10]), 32'hD4);
        check("byte11", 32'(mem_b[8'h11]), 32'hC3);
        check("byte12", 32'(mem_b[8'h12]), 32'hB2);
        check("byte13", 32'(mem_b[8'h13]), 32'hA1);
        check("word14", mem_word(32'h14), 32'h11111111);

        // Five back-to-back stores: nothing lost, order kept
        w0 = writes;
        for (int i = 0; i < 5; i++) do_store(32'h80 + 32'(4 * i), $urandom);
        wait_empty();
        check("five_writes", 32'(writes - w0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            a = 32'h80 + 32'(4 * i);
            check("five_mem", mem_word(a), gold[a]);
        end

        // Same-address stores then an immediate load: youngest value returned
        do_store(32'h20, 32'h1);
        do_store(32'h20, 32'h2);
        do_load(32'h20, got);
        check("fwd_youngest", got, 32'h2);
        wait_empty();
        check("mem20", mem_word(32'h20), 32'h2);

        // Load miss with an empty buffer returns the initial memory pattern
        do_load(32'h40, got);
        check("miss_0x40", got, 32'h43424140);

        // Reset while a drain is on the port
        do_store(32'h30, 32'hDEADBEEF);
        @(negedge CLK);
        #1;
        check("pre_reset_write", 32'(bus.mem_write), 32'd1);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("mid_drain");
        q.delete();
        gold.delete();
        drain_now = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("discarded_store", mem_word(32'h30), 32'h33323130);

        // Random mix of stores and loads over a small address window
        for (int i = 0; i < 200; i++) begin
            a = 32'hC0 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 2) < 2) begin
                do_store(a, $urandom);
            end else begin
                do_load(a, got);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        wait_empty();
        foreach (gold[k]) check("final_mem", mem_word(k), gold[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
